// File: rtl/commit_wb_scheduler.sv
// Purpose : shares one commit/writeback port between NUM_INPUTS commit streams (0=LSU 1=ALU 2=FPU 3=SFU)
//           using round-robin arbitration with sop..eop packet locking.
// Latency : 1 cycle from input accept to valid_out when the output buffer is empty; 1 beat/cycle sustained.
// Backpr. : 2-entry output skid buffer; ready_in depends on registered fill level only, so there is
//           no ready_out->ready_in combinational path.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   valid_in   per-source beat valid
//   ready_in   per-source accept, one-hot or zero
//   data_in    per-source payload (opaque)
//   eop_in     per-source last beat of packet (single-beat packet has eop=1)
//   valid_out  head of output buffer valid
//   ready_out  downstream accept
//   data_out   head payload
//   sel_out    source index of head beat
//   eop_out    eop of head beat
//
// Build option: define COMMIT_SCHED_AGING_EN to add per-input wait counters; an input that has
// waited MAX_STALL cycles preempts round-robin (never a lock).

// Generic synchronous FIFO.
// Latency : pushed entry visible at head the cycle after push.
// Backpr. : none internally; caller must not push when full nor pop when empty.
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // Payload storage carries no reset: contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// Commit writeback scheduler.
// Latency : accept in cycle t with empty buffer -> valid_out in t+1.
// Backpr. : ready_in all zero while the 2-entry buffer is full or reset is asserted.
module commit_wb_scheduler #(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATAW      = 64,
  parameter  int MAX_STALL  = 7,
  localparam int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            valid_in,
  output logic [NUM_INPUTS-1:0]            ready_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]            eop_in,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [DATAW-1:0]                 data_out,
  output logic [SELW-1:0]                  sel_out,
  output logic                             eop_out
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  typedef struct packed {
    logic [DATAW-1:0] dat;
    logic [SELW-1:0]  sel;
    logic             eop;
  } beat_t;

  localparam int BEATW = $bits(beat_t);

  logic [0:0]            state_q;
  logic [SELW-1:0]       owner_q;
  logic [SELW-1:0]       rr_ptr_q;
  logic [1:0]            buf_cnt;
  logic                  acc_en;
  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] aged;
  logic [SELW-1:0]       grant;
  logic                  grant_vld;
  logic                  push;
  logic                  pop;
  beat_t                 push_beat;
  beat_t                 head_beat;

  // Buffer has room; registered state only.
  assign acc_en = (buf_cnt != 2'd2);

  // A held lock masks every other source, even while the owner idles between beats.
  always_comb begin
    eligible = valid_in;
    if (state_q == ST_LOCKED) eligible = valid_in & (NUM_INPUTS'(1) << owner_q);
  end

`ifdef COMMIT_SCHED_AGING_EN
  localparam int              AGEW    = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAX_STALL);

  logic [AGEW-1:0] wait_cnt [NUM_INPUTS];

  // Waiting only counts while the buffer could have taken the beat, so
  // downstream stalls do not age everyone into saturation together.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!reset) begin
        wait_cnt[i] <= '0;
      end else if (valid_in[i] && ready_in[i]) begin
        wait_cnt[i] <= '0;
      end else if (valid_in[i] && !ready_in[i] && acc_en && (wait_cnt[i] != AGE_MAX)) begin
        wait_cnt[i] <= wait_cnt[i] + AGEW'(1);
      end
    end
  end

  // Aging is ignored while locked so a packet is never split.
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      aged[i] = (state_q == ST_UNLOCKED) && eligible[i] && (wait_cnt[i] == AGE_MAX);
    end
  end
`else
  assign aged = '0;
`endif

  // Lowest-index set bit; returns {found, index}.
  function automatic logic [SELW:0] low_pick(input logic [NUM_INPUTS-1:0] vec);
    logic [SELW:0] res;
    res = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!res[SELW] && vec[i]) res = {1'b1, SELW'(i)};
    end
    return res;
  endfunction

  // First set bit strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [SELW:0] rr_pick(input logic [NUM_INPUTS-1:0] vec,
                                            input logic [SELW-1:0]       ptr);
    logic [SELW:0] res;
    int            idx;
    res = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = (int'(ptr) + k) % NUM_INPUTS;
      if (!res[SELW] && vec[idx]) res = {1'b1, SELW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    logic [SELW:0] age_res;
    logic [SELW:0] rr_res;
    age_res = low_pick(aged);
    rr_res  = rr_pick(eligible, rr_ptr_q);
    if (age_res[SELW]) begin
      grant_vld = 1'b1;
      grant     = age_res[SELW-1:0];
    end else begin
      grant_vld = rr_res[SELW];
      grant     = rr_res[SELW-1:0];
    end
  end

  assign ready_in = (reset && acc_en && grant_vld) ? (NUM_INPUTS'(1) << grant) : '0;

  assign push = |(valid_in & ready_in);
  assign pop  = valid_out && ready_out;

  always_comb begin
    push_beat     = '0;
    push_beat.dat = data_in[grant];
    push_beat.sel = grant;
    push_beat.eop = eop_in[grant];
  end

  // Arbiter state: the fired source becomes the new round-robin pointer and,
  // for a non-eop beat, the lock owner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_UNLOCKED;
      owner_q  <= '0;
      rr_ptr_q <= SELW'(NUM_INPUTS - 1);
    end else if (push) begin
      rr_ptr_q <= grant;
      if (eop_in[grant]) begin
        state_q <= ST_UNLOCKED;
      end else begin
        state_q <= ST_LOCKED;
        owner_q <= grant;
      end
    end
  end

  fifo_sync #(
    .WIDTH (BEATW),
    .DEPTH (2)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_beat),
    .pop      (pop),
    .head_dat (head_beat),
    .count    (buf_cnt)
  );

  assign valid_out = (buf_cnt != 2'd0);
  assign data_out  = head_beat.dat;
  assign sel_out   = head_beat.sel;
  assign eop_out   = head_beat.eop;

endmodule

// File: tb/tb_commit_wb_scheduler.sv
// Bench for commit_wb_scheduler: table of per-cycle vectors, hand sequences for
// backpressure / reset / aging, then random traffic against a queue-based model.
module tb_commit_wb_scheduler;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MS = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      valid_in;
  logic [N-1:0]      ready_in;
  logic [N-1:0][DW-1:0] data_in;
  logic [N-1:0]      eop_in;
  logic              valid_out;
  logic              ready_out;
  logic [DW-1:0]     data_out;
  logic [1:0]        sel_out;
  logic              eop_out;

  int n_chk  = 0;
  int n_pass = 0;

  commit_wb_scheduler #(
    .NUM_INPUTS (N),
    .DATAW      (DW),
    .MAX_STALL  (MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .eop_out   (eop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] tag(input int s);
    return 64'hC0DE_0000_0000_0000 | 64'(s);
  endfunction

  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] e, input logic ro);
    reset = r; valid_in = v; eop_in = e; ready_out = ro;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] eop;
    logic       ro;
    logic [3:0] exp_rdy;
    logic       exp_vout;
    logic [1:0] exp_sel;
    logic       exp_eop;
  } vec_t;

  vec_t tbl [20];

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] d;
    int          s;
    logic        e;
  } mbeat_t;

  mbeat_t m_q[$];
  int     m_owner;
  int     m_last;
  int     m_age [N];

  task automatic model_reset();
    m_q.delete();
    m_owner = -1;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  function automatic logic [3:0] model_ready();
    int g;
    g = -1;
    if (!reset || m_q.size() >= 2) return 4'b0000;
    if (m_owner >= 0) begin
      if (valid_in[m_owner]) g = m_owner;
    end else begin
`ifdef COMMIT_SCHED_AGING_EN
      for (int i = 0; i < N; i++) if (g < 0 && valid_in[i] && m_age[i] == MS) g = i;
`endif
      for (int k = 1; k <= N; k++) if (g < 0 && valid_in[(m_last + k) % N]) g = (m_last + k) % N;
    end
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  initial begin
    logic [3:0] exp_rdy;
    int         fire_idx;
    logic       pop_m;
    logic       acc_m;
    mbeat_t     b;

    tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1};
    tbl[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[11] = '{1'b1, 4'b0111, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[12] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1};
    tbl[13] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{1'b1, 4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    tbl[15] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[16] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{1'b1, 4'b0111, 4'b0111, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[19] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < N; i++) data_in[i] = tag(i);
    reset = 1'b0; valid_in = '1; eop_in = '1; ready_out = 1'b1;
    advance();

    // Reset hold, round-robin 0,1,2,3,0, 3-beat lock from input 2, idle owner inside a lock.
    for (int r = 0; r < 20; r++) begin
      apply(tbl[r].rst, tbl[r].vld, tbl[r].eop, tbl[r].ro);
      chk($sformatf("tbl%0d_ready_in", r), ready_in, tbl[r].exp_rdy);
      chk($sformatf("tbl%0d_valid_out", r), valid_out, tbl[r].exp_vout);
      if (tbl[r].exp_vout) begin
        chk($sformatf("tbl%0d_sel_out", r), sel_out, tbl[r].exp_sel);
        chk($sformatf("tbl%0d_eop_out", r), eop_out, tbl[r].exp_eop);
        chk($sformatf("tbl%0d_data_out", r), data_out, tag(int'(tbl[r].exp_sel)));
      end
      advance();
    end

    // Backpressure: two beats taken with ready_out low, then nothing until drained.
    apply(1'b0, 4'b0000, 4'b0000, 1'b1); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b0);
    chk("bp_first_accept", ready_in, 4'b0001); chk("bp_empty", valid_out, 1'b0); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b0);
    chk("bp_second_accept", ready_in, 4'b0010); chk("bp_head0", sel_out, 2'd0); advance();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 4'b1111, 4'b1111, 1'b0);
      chk("bp_full_stall", ready_in, 4'b0000); chk("bp_full_valid", valid_out, 1'b1);
      chk("bp_full_head", sel_out, 2'd0); advance();
    end
    apply(1'b1, 4'b1111, 4'b1111, 1'b1);
    chk("bp_release_still_full", ready_in, 4'b0000); chk("bp_out0", data_out, tag(0)); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b1);
    chk("bp_reaccept", ready_in, 4'b0100); chk("bp_out1", data_out, tag(1)); advance();
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("bp_out2", data_out, tag(2)); chk("bp_out2_valid", valid_out, 1'b1); advance();
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("bp_drained", valid_out, 1'b0); advance();

    // Reset after beat 1 of a 2-beat packet from input 1.
    apply(1'b0, 4'b0000, 4'b0000, 1'b1); advance();
    apply(1'b1, 4'b0010, 4'b0000, 1'b0);
    chk("mid_first_beat", ready_in, 4'b0010); advance();
    apply(1'b0, 4'b0011, 4'b0000, 1'b0);
    chk("mid_in_reset_ready", ready_in, 4'b0000); chk("mid_buffered", valid_out, 1'b1); advance();
    apply(1'b1, 4'b0011, 4'b0011, 1'b1);
    chk("mid_flushed", valid_out, 1'b0); chk("mid_unlocked_grant0", ready_in, 4'b0001); advance();
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("mid_out_sel", sel_out, 2'd0); chk("mid_out_valid", valid_out, 1'b1); advance();

    // Input 3 waits behind a 3-beat ALU packet; aged input wins the next unlocked arbitration.
    apply(1'b0, 4'b0000, 4'b0000, 1'b1); advance();
    apply(1'b1, 4'b1010, 4'b1000, 1'b1); chk("age_alu_beat0", ready_in, 4'b0010); advance();
    apply(1'b1, 4'b1010, 4'b1000, 1'b1); chk("age_alu_beat1", ready_in, 4'b0010); advance();
    apply(1'b1, 4'b1010, 4'b1010, 1'b1); chk("age_lock_held", ready_in, 4'b0010); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b1);
`ifdef COMMIT_SCHED_AGING_EN
    chk("age_preempt", ready_in, 4'b1000); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b1); chk("age_after", ready_in, 4'b0001); advance();
`else
    chk("rr_after_lock", ready_in, 4'b0100); advance();
    apply(1'b1, 4'b1111, 4'b1111, 1'b1); chk("rr_after_lock2", ready_in, 4'b1000); advance();
`endif

    // Random traffic against the model.
    apply(1'b0, 4'b0000, 4'b0000, 1'b1); advance();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        valid_in[i] = ($urandom_range(0, 3) != 0);
        eop_in[i]   = ($urandom_range(0, 2) != 0);
        data_in[i]  = {$urandom(), $urandom()};
      end
      ready_out = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = model_ready();
      chk("rnd_ready_in", ready_in, exp_rdy);
      chk("rnd_valid_out", valid_out, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("rnd_data_out", data_out, m_q[0].d);
        chk("rnd_sel_out", sel_out, 64'(m_q[0].s));
        chk("rnd_eop_out", eop_out, m_q[0].e);
      end
      fire_idx = -1;
      for (int i = 0; i < N; i++) if (exp_rdy[i] && valid_in[i]) fire_idx = i;
      pop_m = (m_q.size() != 0) && ready_out;
      acc_m = (m_q.size() < 2);
      advance();
      if (!reset) begin
        model_reset();
      end else begin
        if (pop_m) void'(m_q.pop_front());
        for (int i = 0; i < N; i++) begin
          if (i == fire_idx) m_age[i] = 0;
          else if (valid_in[i] && !exp_rdy[i] && acc_m && m_age[i] < MS) m_age[i]++;
        end
        if (fire_idx >= 0) begin
          b.d = data_in[fire_idx]; b.s = fire_idx; b.e = eop_in[fire_idx];
          m_q.push_back(b);
          m_last  = fire_idx;
          m_owner = eop_in[fire_idx] ? -1 : fire_idx;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/commit_wb_scheduler.md
# commit_wb_scheduler

Per-issue-slice scheduler that shares one register-file writeback/commit port between execution-unit commit streams (LSU, ALU, FPU, SFU). It replaces the generic stream arbiter in front of commit with round-robin arbitration, multi-beat packet locking (sop..eop), optional starvation aging and a 2-entry output skid buffer. It sits between the execution units' commit interfaces and the commit/writeback stage, one instance per issue slot.

## Interface
- NUM_INPUTS, 4, number of commit sources; index 0 = LSU, 1 = ALU, 2 = FPU, 3 = SFU.
- DATAW, 64, commit payload width; opaque to the block.
- MAX_STALL, 7, aging threshold in cycles (≥1). Used only when aging is compiled in.
- SELW, derived, $clog2(NUM_INPUTS), minimum 1.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset: state is cleared on a rising clk edge while reset==0.
- valid_in  in  NUM_INPUTS  per-source beat valid.
- ready_in  out  NUM_INPUTS  per-source accept; at most one bit high per cycle.
- data_in  in  NUM_INPUTS×DATAW  per-source payload.
- eop_in  in  NUM_INPUTS  per-source last beat of a packet; a single-beat packet has eop=1.
- valid_out  out  1  head of output buffer valid.
- ready_out  in  1  downstream accept.
- data_out  out  DATAW  head payload.
- sel_out  out  SELW  source index of the head beat.
- eop_out  out  1  eop of the head beat.

## Operation
- Fire: an input beat fires when valid_in[i] && ready_in[i]. An output beat fires when valid_out && ready_out.
- Output buffer: 2-entry FIFO of {data, sel, eop} with registered count 0..2.
  - valid_out = (count != 0). data_out, sel_out and eop_out come from the head entry.
- Accept enable: acc_en = (count != 2). It depends on registered state only, so there is no ready_out→ready_in combinational path.
- Arbiter FSM:
  - UNLOCKED: eligible = valid_in.
  - LOCKED(owner): eligible = valid_in & onehot(owner). Other inputs get ready_in=0 even if owner is not valid.
- Grant in UNLOCKED:
  - If aging is enabled and any eligible input has wait_cnt==MAX_STALL, the lowest such index wins.
  - Otherwise round-robin: first eligible index after rr_ptr, wrapping modulo NUM_INPUTS.
- ready_in = onehot(grant) when acc_en && (eligible != 0); otherwise 0.
- On input fire from source g:
  - push the beat;
  - rr_ptr <= g;
  - if eop_in[g]==0, go to LOCKED(g);
  - if eop_in[g]==1, go to (or stay in) UNLOCKED.
- Locked packets are never interleaved: all beats sop..eop of one source are contiguous at the output.
- Count update: count += push − pop. Push and pop in the same cycle at count 1 leave count at 1. Push cannot occur at count 2.
- Reset values:
  - count=0, so valid_out=0;
  - state UNLOCKED;
  - rr_ptr=NUM_INPUTS−1, so input 0 has first priority;
  - wait_cnt=0;
  - ready_in=0 while reset==0;
  - data_out, sel_out and eop_out are don't-care while valid_out=0.
- Reset mid-packet: the lock is dropped and buffered beats are discarded; nothing is replayed.

## Timing
- Latency: a beat accepted in cycle t with the buffer empty appears on valid_out in cycle t+1.
- Throughput: 1 beat/cycle sustained while ready_out stays high.
- Backpressure: with ready_out low, two beats are accepted, then all ready_in are 0 from the cycle after count reaches 2. The cycle after ready_out returns high, acc_en is 1 again.
- Lock release: after the eop beat fires in cycle t, any source may be granted in t+1.
- Arbitration is combinational from valid_in and registered state. Round-robin fairness: a continuously valid source in UNLOCKED waits at most NUM_INPUTS−1 grants, excluding lock durations.

## Configuration
- COMMIT_SCHED_AGING_EN defined:
  - one counter per input, width $clog2(MAX_STALL+1);
  - the counter increments (saturating at MAX_STALL) each cycle valid_in[i] && !ready_in[i] && acc_en;
  - it clears when that input fires;
  - a saturated input preempts round-robin in UNLOCKED, but never breaks a lock.
- Undefined: the counters are not instantiated and arbitration is pure round-robin.

## Test plan
- Reset: hold reset=0 for 3 cycles with all valid_in=1 → ready_in=0 and valid_out=0 throughout; first grant after release goes to input 0.
- Round-robin: all 4 inputs valid, single-beat packets, ready_out=1 → sel_out sequence is 0,1,2,3,0 starting 1 cycle after the first accept.
- Locking: input 2 sends a 3-beat packet (eop on 3rd beat) while inputs 0 and 1 are valid → output beats are 2,2,2 contiguous; input 0 is granted the cycle after the eop fire.
- Backpressure: ready_out=0 with inputs streaming → exactly 2 beats accepted, then ready_in=0. Raise ready_out → data comes out in order with no loss or duplication, 1 beat/cycle.
- Aging (COMMIT_SCHED_AGING_EN, MAX_STALL=2): input 3 is blocked 2 cycles behind a long ALU stream → input 3 is granted at the next unlocked arbitration, ahead of the round-robin order.
- Reset mid-packet: drop reset after beat 1 of a 2-beat packet from input 1 → count=0 and UNLOCKED after release; input 0 is granted first.
